// File: rtl/riscv_pkg.sv
// Shared types for the riscv core: Wishbone arbiter state and master identifiers.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } wb_arb_state_t;

  typedef enum logic {
    I = 1'b0,
    D = 1'b1
  } wb_master_t;

endpackage

// File: rtl/riscv_wb_outstanding.sv
// Saturating up/down count of accepted-but-unterminated Wishbone requests,
// with a synchronous clear used when the owning master aborts its cycle.
module riscv_wb_outstanding #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [CW-1:0] cnt_q;

  assign full_o  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  // Simultaneous inc/dec leaves the count alone; neither edge may wrap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Two-master (IFU/LSU) to one-slave pipelined Wishbone arbiter with outstanding tracking.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin contention; default is data-master priority.
module riscv_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          i_cyc_i,
  input  logic          i_stb_i,
  input  logic          i_we_i,
  input  logic [29:0]   i_addr_i,
  input  logic [3:0]    i_sel_i,
  input  logic [31:0]   i_data_i,
  output logic          i_ack_o,
  output logic          i_err_o,
  output logic          i_stall_o,
  output logic [31:0]   i_data_o,
  input  logic          d_cyc_i,
  input  logic          d_stb_i,
  input  logic          d_we_i,
  input  logic [29:0]   d_addr_i,
  input  logic [3:0]    d_sel_i,
  input  logic [31:0]   d_data_i,
  output logic          d_ack_o,
  output logic          d_err_o,
  output logic          d_stall_o,
  output logic [31:0]   d_data_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [29:0]   wb_addr_o,
  output logic [3:0]    wb_sel_o,
  output logic [31:0]   wb_data_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_stall_i,
  input  logic [31:0]   wb_data_i,
  output wb_arb_state_t dbg_state_o,
  output logic [3:0]    dbg_cnt_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  wb_arb_state_t state_q;
  wb_arb_state_t contend_state;
  logic          sel_i, sel_d, granted;
  logic          m_cyc, m_stb, m_we;
  logic [29:0]   m_addr;
  logic [3:0]    m_sel;
  logic [31:0]   m_data;
  logic [CW-1:0] cnt;
  logic          full, empty;
  logic          inc, dec, abort;

  assign sel_i   = (state_q == GRANT_I);
  assign sel_d   = (state_q == GRANT_D);
  assign granted = sel_i | sel_d;

  assign m_cyc  = sel_d ? d_cyc_i  : i_cyc_i;
  assign m_stb  = sel_d ? d_stb_i  : i_stb_i;
  assign m_we   = sel_d ? d_we_i   : i_we_i;
  assign m_addr = sel_d ? d_addr_i : i_addr_i;
  assign m_sel  = sel_d ? d_sel_i  : i_sel_i;
  assign m_data = sel_d ? d_data_i : i_data_i;

`ifdef WB_ARB_ROUND_ROBIN_EN
  wb_master_t last_grant_q;

  // Tracks whichever master currently owns (or last owned) the bus.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant_q <= I;
    end else if (sel_i) begin
      last_grant_q <= I;
    end else if (sel_d) begin
      last_grant_q <= D;
    end
  end

  assign contend_state = (last_grant_q == D) ? GRANT_I : GRANT_D;
`else
  assign contend_state = GRANT_D;
`endif

  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_addr_o = '0;
    wb_sel_o  = '0;
    wb_data_o = '0;
    if (granted) begin
      wb_cyc_o  = m_cyc;
      wb_stb_o  = m_cyc & m_stb & ~full;
      wb_we_o   = m_we;
      wb_addr_o = m_addr;
      wb_sel_o  = m_sel;
      wb_data_o = m_data;
    end
  end

  assign i_stall_o = sel_i ? (wb_stall_i | full) : 1'b1;
  assign d_stall_o = sel_d ? (wb_stall_i | full) : 1'b1;
  assign i_ack_o   = sel_i & wb_ack_i;
  assign d_ack_o   = sel_d & wb_ack_i;
  assign i_err_o   = sel_i & wb_err_i;
  assign d_err_o   = sel_d & wb_err_i;
  assign i_data_o  = wb_data_i;
  assign d_data_o  = wb_data_i;

  // Err terminates a request exactly like ack; dropping cyc with work in flight discards it.
  assign inc   = wb_stb_o & ~wb_stall_i;
  assign dec   = granted & (wb_ack_i | wb_err_i);
  assign abort = granted & ~m_cyc & ~empty;

  riscv_wb_outstanding #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (abort),
    .inc_i   (inc),
    .dec_i   (dec),
    .cnt_o   (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  // Grant is held for the whole cycle; release hands straight over to a waiting master.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_cyc_i && d_cyc_i) state_q <= contend_state;
          else if (d_cyc_i)       state_q <= GRANT_D;
          else if (i_cyc_i)       state_q <= GRANT_I;
        end
        GRANT_I: begin
          if (!i_cyc_i) state_q <= d_cyc_i ? GRANT_D : IDLE;
        end
        GRANT_D: begin
          if (!d_cyc_i) state_q <= i_cyc_i ? GRANT_I : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = 4'(cnt);

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed self-checking bench for riscv_wb_arbiter (MAX_OUTSTANDING = 4).
module tb_riscv_wb_arbiter;
  import riscv_pkg::*;

  logic          clk, reset_i;
  logic          i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
  logic [29:0]   i_addr, d_addr;
  logic [3:0]    i_sel, d_sel;
  logic [31:0]   i_wdata, d_wdata;
  logic          i_ack, i_err, i_stall, d_ack, d_err, d_stall;
  logic [31:0]   i_rdata, d_rdata;
  logic          wb_cyc, wb_stb, wb_we;
  logic [29:0]   wb_addr;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_wdata, wb_rdata;
  logic          wb_ack, wb_err, wb_stall;
  wb_arb_state_t dbg_state;
  logic [3:0]    dbg_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int acc;
  logic [31:0] exp_q[$];
  logic [31:0] exp_contend2;

  riscv_wb_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .i_cyc_i(i_cyc), .i_stb_i(i_stb), .i_we_i(i_we), .i_addr_i(i_addr),
    .i_sel_i(i_sel), .i_data_i(i_wdata),
    .i_ack_o(i_ack), .i_err_o(i_err), .i_stall_o(i_stall), .i_data_o(i_rdata),
    .d_cyc_i(d_cyc), .d_stb_i(d_stb), .d_we_i(d_we), .d_addr_i(d_addr),
    .d_sel_i(d_sel), .d_data_i(d_wdata),
    .d_ack_o(d_ack), .d_err_o(d_err), .d_stall_o(d_stall), .d_data_o(d_rdata),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_addr_o(wb_addr),
    .wb_sel_o(wb_sel), .wb_data_o(wb_wdata),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_stall_i(wb_stall), .wb_data_i(wb_rdata),
    .dbg_state_o(dbg_state), .dbg_cnt_o(dbg_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    i_cyc = 0; i_stb = 0; i_we = 0; i_addr = '0; i_sel = 4'hf; i_wdata = 32'h1111_0000;
    d_cyc = 0; d_stb = 0; d_we = 0; d_addr = '0; d_sel = 4'h3; d_wdata = 32'h2222_0000;
    wb_ack = 0; wb_err = 0; wb_stall = 0; wb_rdata = '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_contend2 = 32'(GRANT_I);
`else
    exp_contend2 = 32'(GRANT_D);
`endif

    // reset state
    #3;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_cnt", 32'(dbg_cnt), 0);
    check("rst_wb_cyc", 32'(wb_cyc), 0);
    check("rst_stalls", {30'd0, i_stall, d_stall}, 32'h3);
    tick(); tick();
    reset_i = 1'b0;

    // single read from I
    tick();
    i_cyc = 1; i_stb = 1; i_addr = 30'h10;
    #1;
    check("t1_idle_stall", 32'(i_stall), 1);
    check("t1_idle_stb", 32'(wb_stb), 0);
    tick();
    #1;
    check("t1_state", 32'(dbg_state), 32'(GRANT_I));
    check("t1_addr", 32'(wb_addr), 32'h10);
    check("t1_i_stall", 32'(i_stall), 0);
    check("t1_stb", 32'(wb_stb), 1);
    check("t1_sel", 32'(wb_sel), 32'hf);
    if (wb_stb && !wb_stall) exp_q.push_back(32'hDEAD_BEEF);
    tick();
    i_stb = 0;
    #1;
    check("t1_cnt1", 32'(dbg_cnt), 1);
    tick();
    tick();
    wb_ack = 1; wb_rdata = 32'hDEAD_BEEF;
    #1;
    check("t1_i_ack", 32'(i_ack), 1);
    check("t1_d_ack", 32'(d_ack), 0);
    check("t1_sb_depth", 32'(exp_q.size()), 1);
    if (exp_q.size() != 0) check("t1_i_data", i_rdata, exp_q.pop_front());
    check("t1_d_data", d_rdata, 32'hDEAD_BEEF);
    tick();
    wb_ack = 0; i_cyc = 0;
    #1;
    check("t1_cnt0", 32'(dbg_cnt), 0);
    check("t1_held", 32'(dbg_state), 32'(GRANT_I));
    tick();
    check("t1_idle", 32'(dbg_state), 32'(IDLE));
    check("t1_idle_cyc", 32'(wb_cyc), 0);

    // contention twice
    i_cyc = 1; d_cyc = 1; i_addr = 30'h20; d_addr = 30'h30;
    tick();
    check("t2_first", 32'(dbg_state), 32'(GRANT_D));
    check("t2_addr", 32'(wb_addr), 32'h30);
    check("t2_stalls", {30'd0, i_stall, d_stall}, 32'h2);
    i_cyc = 0; d_cyc = 0;
    tick();
    check("t2_idle", 32'(dbg_state), 32'(IDLE));
    i_cyc = 1; d_cyc = 1;
    tick();
    check("t2_second", 32'(dbg_state), exp_contend2);
    i_cyc = 0; d_cyc = 0;
    tick();

    // pipelined burst from D, acks held off
    d_cyc = 1; d_stb = 1; d_we = 1; d_addr = 30'h40;
    tick();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("t3_stall%0d", k), 32'(d_stall), (k < 4) ? 32'd0 : 32'd1);
      if (wb_stb && !wb_stall) acc++;
      tick();
    end
    #1;
    check("t3_accepted", 32'(acc), 4);
    check("t3_cnt_full", 32'(dbg_cnt), 4);
    check("t3_we", 32'(wb_we), 1);
    wb_ack = 1;
    #1;
    check("t3_ack", 32'(d_ack), 1);
    check("t3_stb_gated", 32'(wb_stb), 0);
    tick();
    wb_ack = 0;
    #1;
    check("t3_cnt3", 32'(dbg_cnt), 3);
    check("t3_unstall", 32'(d_stall), 0);
    if (wb_stb && !wb_stall) acc++;
    tick();
    check("t3_accepted5", 32'(acc), 5);
    check("t3_cnt_refill", 32'(dbg_cnt), 4);
    check("t3_restall", 32'(d_stall), 1);
    d_stb = 0;
    wb_ack = 1;
    tick();
    tick();
    wb_ack = 0;
    #1;
    check("t3_cnt2", 32'(dbg_cnt), 2);

    // abort with two outstanding
    d_cyc = 0;
    #1;
    check("t5_abort_cyc", 32'(wb_cyc), 0);
    tick();
    check("t5_abort_cnt", 32'(dbg_cnt), 0);
    check("t5_abort_state", 32'(dbg_state), 32'(IDLE));
    wb_ack = 1;
    #1;
    check("t5_late_ack", {30'd0, i_ack, d_ack}, 0);
    tick();
    wb_ack = 0;
    #1;
    check("t5_late_cnt", 32'(dbg_cnt), 0);

    // handoff D -> I without IDLE
    d_we = 0; d_cyc = 1; d_addr = 30'h60;
    i_cyc = 1; i_stb = 1; i_addr = 30'h50;
    tick();
    check("t4_d_first", 32'(dbg_state), 32'(GRANT_D));
    check("t4_i_stall", 32'(i_stall), 1);
    check("t4_d_addr", 32'(wb_addr), 32'h60);
    d_cyc = 0;
    tick();
    check("t4_handoff", 32'(dbg_state), 32'(GRANT_I));
    check("t4_i_addr", 32'(wb_addr), 32'h50);
    check("t4_i_go", 32'(i_stall), 0);

    // error termination in GRANT_I
    tick();
    i_stb = 0;
    #1;
    check("t6_cnt1", 32'(dbg_cnt), 1);
    wb_stall = 1;
    #1;
    check("t6_stall_pass", 32'(i_stall), 1);
    wb_stall = 0;
    wb_err = 1;
    #1;
    check("t6_i_err", 32'(i_err), 1);
    check("t6_d_err", 32'(d_err), 0);
    tick();
    wb_err = 0;
    #1;
    check("t6_cnt0", 32'(dbg_cnt), 0);
    check("t6_held", 32'(dbg_state), 32'(GRANT_I));
    tick();
    check("t6_still_held", 32'(dbg_state), 32'(GRANT_I));

    // asynchronous reset in GRANT_I
    reset_i = 1;
    #1;
    check("t7_state", 32'(dbg_state), 32'(IDLE));
    check("t7_wb_cyc", 32'(wb_cyc), 0);
    check("t7_i_stall", 32'(i_stall), 1);
    check("t7_addr", 32'(wb_addr), 0);
    tick();
    reset_i = 0; i_cyc = 0;
    tick();
    check("t7_post", 32'(dbg_state), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
